// File: rtl/router_pkg.sv
// Shared types and helpers for the 1xN packet router.
// Holds the FSM state encoding and the destination-width helper.
package router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ROUTE = 2'b01,
        ST_WAIT  = 2'b10
    } state_t;

    function automatic int DEST_W(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/router_port_fifo.sv
// First-word fall-through FIFO for one router output port.
// Head entry is driven straight from storage, so a pushed beat is visible one cycle later.
module router_port_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_1xn_fifo.sv
// 1xN packet router: steers each packet into the FIFO of the port named on its first beat.
// A full destination FIFO stalls the input only; other ports keep draining.
module router_1xn_fifo
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pkt_valid,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [DEST_W(NUM_PORTS)-1:0]  dest_addr,
    output logic                          ready_in,
    input  logic [NUM_PORTS-1:0]          ready_out,
    output logic [NUM_PORTS-1:0]          valid_out,
    output logic [NUM_PORTS*DATA_W-1:0]   data_out,
    output logic [1:0]                    state_out
);

    localparam int DW = DEST_W(NUM_PORTS);

    state_t               state;
    state_t               state_next;
    logic [DW-1:0]        dest_q;
    logic [DW-1:0]        dest_next;
    logic [DW-1:0]        sel;
    logic                 accept;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] push;

    // The first beat of a packet routes on the live dest_addr; later beats use the latched one.
    assign sel       = (state == ST_IDLE) ? dest_addr : dest_q;
    assign ready_in  = !full[sel];
    assign state_out = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            dest_q <= '0;
        end else begin
            state  <= state_next;
            dest_q <= dest_next;
        end
    end

    always_comb begin
        state_next = state;
        dest_next  = dest_q;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pkt_valid) begin
                    dest_next = dest_addr;
                    if (!full[sel]) begin
                        accept     = 1'b1;
                        state_next = ST_ROUTE;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_ROUTE: begin
                if (!pkt_valid) begin
                    state_next = ST_IDLE;
                end else if (!full[sel]) begin
                    accept = 1'b1;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!pkt_valid) begin
                    state_next = ST_IDLE;
                end else if (!full[sel]) begin
                    accept     = 1'b1;
                    state_next = ST_ROUTE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        push      = '0;
        push[sel] = accept;
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        router_port_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_data (data_in),
            .full      (full[i]),
            .pop       (ready_out[i] && !empty[i]),
            .head      (data_out[i*DATA_W +: DATA_W]),
            .empty     (empty[i])
        );
        assign valid_out[i] = !empty[i];
    end

endmodule

// File: tb/tb_router_1xn_fifo.sv
// Bench for router_1xn_fifo: directed scenarios plus random packets against a queue-based model.
module tb_router_1xn_fifo;

    localparam int NUM_PORTS  = 4;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        pkt_valid;
    logic [DATA_W-1:0]           data_in;
    logic [1:0]                  dest_addr;
    logic                        ready_in;
    logic [NUM_PORTS-1:0]        ready_out;
    logic [NUM_PORTS-1:0]        valid_out;
    logic [NUM_PORTS*DATA_W-1:0] data_out;
    logic [1:0]                  state_out;

    int tests = 0;
    int fails = 0;

    // Model: one expected queue per port, plus packet-level bookkeeping.
    logic [DATA_W-1:0] exp_q [NUM_PORTS][$];
    bit                m_in_pkt = 0;
    int                m_dest   = 0;
    logic [1:0]        m_state  = 2'b00;
    bit                m_acc    = 0;
    bit                rand_ready = 0;
    logic [DATA_W-1:0] pkt_data [16];
    int                pkt_len;

    router_1xn_fifo #(
        .NUM_PORTS  (NUM_PORTS),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .dest_addr (dest_addr),
        .ready_in  (ready_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, then advance the model across the rising edge.
    task automatic cycle();
        int         sel;
        bit         exp_ready;
        logic [NUM_PORTS-1:0] pops;
        @(negedge clk);
        sel       = m_in_pkt ? m_dest : int'(dest_addr);
        exp_ready = exp_q[sel].size() < FIFO_DEPTH;
        if (!rst) begin
            check("ready_in", 64'(ready_in), 64'(exp_ready));
            check("state", 64'(state_out), 64'(m_state));
            for (int p = 0; p < NUM_PORTS; p++) begin
                check($sformatf("valid_out%0d", p), 64'(valid_out[p]), 64'(exp_q[p].size() > 0));
                if (exp_q[p].size() > 0)
                    check($sformatf("data_out%0d", p), 64'(data_out[p*DATA_W +: DATA_W]), 64'(exp_q[p][0]));
            end
        end
        m_acc = !rst && pkt_valid && exp_ready;
        for (int p = 0; p < NUM_PORTS; p++)
            pops[p] = ready_out[p] && (exp_q[p].size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) exp_q[p].delete();
            m_in_pkt = 0;
            m_dest   = 0;
            m_state  = 2'b00;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                if (pops[p]) void'(exp_q[p].pop_front());
            if (m_acc) exp_q[sel].push_back(data_in);
            if (!pkt_valid) begin
                m_in_pkt = 0;
                m_state  = 2'b00;
            end else begin
                if (!m_in_pkt) m_dest = int'(dest_addr);
                m_in_pkt = 1;
                m_state  = m_acc ? 2'b01 : 2'b10;
            end
        end
    endtask

    // Sends pkt_data[0..pkt_len-1], holding each beat until accepted, then one idle cycle.
    task automatic send_pkt(input int dest, input int dest_later);
        int stall;
        for (int i = 0; i < pkt_len; i++) begin
            pkt_valid = 1'b1;
            data_in   = pkt_data[i];
            dest_addr = 2'((i == 0) ? dest : dest_later);
            stall     = 0;
            do begin
                if (rand_ready) ready_out = 4'($urandom_range(0, 15));
                cycle();
                stall++;
            end while (!m_acc && stall < 300);
            if (!m_acc) begin
                check("stall_bound", 64'(0), 64'(1));
                break;
            end
        end
        pkt_valid = 1'b0;
        dest_addr = 2'($urandom_range(0, 3));
        cycle();
    endtask

    task automatic drain(input int n);
        pkt_valid = 1'b0;
        ready_out = '1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; pkt_valid = 1'b0; data_in = '0; dest_addr = '0; ready_out = 4'hF;
        cycle();
        rst = 1'b0;
        check("rst_valid_out", 64'(valid_out), 64'(0));
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_ready_in", 64'(ready_in), 64'(1));
        check("rst_state", 64'(state_out), 64'(0));

        // Single beat to port 0.
        pkt_valid = 1'b1; data_in = 8'hA1; dest_addr = 2'd0;
        cycle();
        check("a_valid_out", 64'(valid_out), 64'(4'b0001));
        check("a_data0", 64'(data_out[7:0]), 64'(8'hA1));
        check("a_state_route", 64'(state_out), 64'(2'b01));
        pkt_valid = 1'b0;
        cycle();
        check("a_drained", 64'(valid_out), 64'(0));
        check("a_state_idle", 64'(state_out), 64'(2'b00));

        // Destination changes mid-packet are ignored.
        ready_out = 4'b0000;
        pkt_len = 3; pkt_data[0] = 8'hB1; pkt_data[1] = 8'hB2; pkt_data[2] = 8'hB3;
        send_pkt(1, 3);
        check("b_port3_empty", 64'(valid_out[3]), 64'(0));
        check("b_port1_head", 64'(data_out[15:8]), 64'(8'hB1));
        drain(4);

        // Port 2 stalled: 4 beats fill it, the 5th forces WAIT.
        ready_out = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            pkt_valid = 1'b1; data_in = 8'hC0 + 8'(i); dest_addr = (i == 0) ? 2'd2 : 2'd0;
            cycle();
            check("c_accept", 64'(m_acc), 64'(1));
        end
        data_in = 8'hC4;
        cycle();
        check("c_ready_low", 64'(ready_in), 64'(0));
        check("c_state_wait", 64'(state_out), 64'(2'b10));
        cycle();
        ready_out = 4'b1111;
        for (int i = 4; i < 6; i++) begin
            data_in = 8'hC0 + 8'(i);
            for (int s = 0; s < 10; s++) begin
                cycle();
                if (m_acc) break;
            end
            check("c_late_accept", 64'(m_acc), 64'(1));
        end
        pkt_valid = 1'b0;
        drain(6);

        // Port 3 full and stalled does not block a packet to port 0.
        ready_out = 4'b0111;
        pkt_len = 4;
        for (int i = 0; i < 4; i++) pkt_data[i] = 8'h30 + 8'(i);
        send_pkt(3, 3);
        pkt_valid = 1'b1; data_in = 8'hD0; dest_addr = 2'd0;
        cycle();
        check("d_accept", 64'(m_acc), 64'(1));
        check("d_valid_out", 64'(valid_out), 64'(4'b1001));
        pkt_valid = 1'b0;
        drain(6);

        // Back-to-back packets with continuous draining.
        ready_out = 4'hF;
        pkt_len = 3;
        for (int i = 0; i < 3; i++) pkt_data[i] = 8'h10 + 8'(i);
        send_pkt(1, 1);
        for (int i = 0; i < 3; i++) pkt_data[i] = 8'h20 + 8'(i);
        send_pkt(2, 2);
        check("e_idle_empty", 64'(valid_out), 64'(0));

        // Reset mid-packet discards buffered beats.
        ready_out = 4'b0000;
        pkt_valid = 1'b1; dest_addr = 2'd1;
        data_in = 8'hE0; cycle();
        data_in = 8'hE1; dest_addr = 2'd0; cycle();
        rst = 1'b1; data_in = 8'hE2; cycle();
        rst = 1'b0;
        check("f_valid_out", 64'(valid_out), 64'(0));
        check("f_state", 64'(state_out), 64'(0));
        check("f_ready_in", 64'(ready_in), 64'(1));
        dest_addr = 2'd3; data_in = 8'hE3; cycle();
        check("f_new_dest", 64'(valid_out), 64'(4'b1000));
        data_in = 8'hE4; dest_addr = 2'd2; cycle();
        pkt_valid = 1'b0;
        drain(6);

        // Random packets with random consumer back-pressure.
        rand_ready = 1;
        for (int n = 0; n < 80; n++) begin
            pkt_len = $urandom_range(1, 7);
            for (int i = 0; i < pkt_len; i++) pkt_data[i] = 8'($urandom);
            send_pkt($urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                ready_out = 4'($urandom_range(0, 15));
                cycle();
            end
        end
        rand_ready = 0;
        drain(8);
        check("final_empty", 64'(valid_out), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
